data_mux_rr: RTL

DATA_MUX_RR -- requirements
Module: data_mux_rr

---
 rtl/data_mux_rr.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/data_mux_rr.sv
// data_mux_rr: N-input stream multiplexer with one output register stage.
// It runs in FILL (idle words only) or RUN (forward stream data). The source
// is either a fixed stream index or a round-robin scan over the valid streams.
// Orbit-sync and link-reset pulses are held pending until the next load, so a
// word already in the output register is never dropped or altered.
module data_mux_rr #(
  parameter int DATA_WIDTH          = 32,
  parameter int N_INPUTS            = 4,
  parameter bit OUTPUT_REVERSE_BITS = 1'b1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] tdata_in,
  input  logic [N_INPUTS-1:0]            tvalid_in,
  output logic [N_INPUTS-1:0]            tready_in,
  output logic [DATA_WIDTH-1:0]          tdata_out,
  output logic                           tvalid_out,
  input  logic                           tready_out,
  input  logic                           mode,
  input  logic [3:0]                     output_select,
  input  logic [15:0]                    n_idle_words,
  input  logic [DATA_WIDTH-1:0]          idle_word,
  input  logic [DATA_WIDTH-1:0]          idle_word_BX0,
  input  logic                           fc_orbitSync,
  input  logic                           fc_linkReset,
  output logic                           fill_active
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic [15:0]           fill_cnt_reg, fill_cnt_next;
  logic [3:0]            rr_ptr_reg, rr_ptr_next;
  logic                  bx0_pending_reg, bx0_pending_next;
  logic                  lr_pending_reg, lr_pending_next;

  logic                  load_en;
  logic                  do_load;
  logic                  load_idle;
  logic                  run_ok;
  logic [3:0]            rr_sel;
  logic [4:0]            rr_idx;
  logic [4:0]            rr_inc;
  logic [3:0]            sel;
  logic                  sel_in_range;
  logic                  sel_valid;
  logic [15:0]           valid_pad;
  logic [DATA_WIDTH-1:0] data_arr [16];
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] word_out;

  genvar gi;

  // Pad the stream vectors to 16 entries so a 4-bit select can index them
  // directly; entries beyond N_INPUTS read as not valid.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pad
      if (gi < N_INPUTS) begin : g_used
        assign valid_pad[gi] = tvalid_in[gi];
        assign data_arr[gi]  = tdata_in[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_unused
        assign valid_pad[gi] = 1'b0;
        assign data_arr[gi]  = '0;
      end
    end
  endgenerate

  // Round-robin scan: walk from the farthest offset back to rr_ptr so the
  // first valid stream at or after rr_ptr wins.
  always_comb begin
    rr_sel = rr_ptr_reg;
    rr_idx = '0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      rr_idx = {1'b0, rr_ptr_reg} + 5'(k);
      if (rr_idx >= 5'(N_INPUTS)) begin
        rr_idx = rr_idx - 5'(N_INPUTS);
      end
      if (valid_pad[rr_idx[3:0]]) begin
        rr_sel = rr_idx[3:0];
      end
    end
  end

  assign load_en      = !tvalid_out || tready_out;
  assign sel          = mode ? rr_sel : output_select;
  assign sel_in_range = ({1'b0, sel} < 5'(N_INPUTS));
  assign sel_valid    = sel_in_range && valid_pad[sel];
  assign run_ok       = (state_reg == ST_RUN) && load_en && !lr_pending_reg;
  assign rr_inc       = {1'b0, sel} + 5'd1;
  assign fill_active  = (state_reg == ST_FILL);

  // Only the selected in-range stream sees ready, and only when its word
  // would actually be loaded this cycle.
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_ready
      assign tready_in[gi] = run_ok && (sel == 4'(gi));
    end
  endgenerate

  // Next-state logic: link reset first, then FILL sequencing, then RUN.
  always_comb begin
    state_next       = state_reg;
    fill_cnt_next    = fill_cnt_reg;
    rr_ptr_next      = rr_ptr_reg;
    bx0_pending_next = bx0_pending_reg;
    lr_pending_next  = lr_pending_reg;
    do_load          = 1'b0;
    load_idle        = 1'b1;

    if (lr_pending_reg) begin
      if (load_en) begin
        do_load         = 1'b1;
        state_next      = ST_FILL;
        fill_cnt_next   = '0;
        rr_ptr_next     = '0;
        lr_pending_next = 1'b0;
      end
    end else if (state_reg == ST_FILL) begin
      if (n_idle_words == 16'd0) begin
        state_next    = ST_RUN;
        fill_cnt_next = '0;
      end else if (load_en) begin
        do_load = 1'b1;
        if (({1'b0, fill_cnt_reg} + 17'd1) >= {1'b0, n_idle_words}) begin
          state_next    = ST_RUN;
          fill_cnt_next = '0;
        end else begin
          fill_cnt_next = fill_cnt_reg + 16'd1;
        end
      end
    end else if (load_en) begin
      do_load = 1'b1;
      if (sel_valid) begin
        load_idle = 1'b0;
        if (mode) begin
          rr_ptr_next = (rr_inc == 5'(N_INPUTS)) ? 4'd0 : rr_inc[3:0];
        end
      end
    end

    // The BX0 marker is consumed by the first idle word actually loaded;
    // a fresh pulse always leaves a pending request behind.
    if (do_load && load_idle && bx0_pending_reg) begin
      bx0_pending_next = 1'b0;
    end
    if (fc_orbitSync) begin
      bx0_pending_next = 1'b1;
    end
    if (fc_linkReset) begin
      lr_pending_next = 1'b1;
    end
  end

  assign word_next = load_idle ? (bx0_pending_reg ? idle_word_BX0 : idle_word)
                               : data_arr[sel];

  // Optional bit reversal of every word entering the output register.
  generate
    if (OUTPUT_REVERSE_BITS) begin : g_rev
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        assign word_out[gi] = word_next[DATA_WIDTH-1-gi];
      end
    end else begin : g_norev
      assign word_out = word_next;
    end
  endgenerate

  // Control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_FILL;
      fill_cnt_reg    <= '0;
      rr_ptr_reg      <= '0;
      bx0_pending_reg <= 1'b0;
      lr_pending_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fill_cnt_reg    <= fill_cnt_next;
      rr_ptr_reg      <= rr_ptr_next;
      bx0_pending_reg <= bx0_pending_next;
      lr_pending_reg  <= lr_pending_next;
    end
  end

  // Output register: loads only on do_load, otherwise holds its word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tdata_out  <= '0;
      tvalid_out <= 1'b0;
    end else if (do_load) begin
      tdata_out  <= word_out;
      tvalid_out <= 1'b1;
    end
  end

endmodule
